// File: rtl/three_d_memory_ecc_corrector.sv
// three_d_memory_ecc_corrector
// Two-stage streaming SEC decoder for the 16-bit 3D-memory ECC codeword
// (8 data bits, 4 layer-parity, 2 bit-parity, 1 overall-parity, bit 15 spare).
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake, codeword_in = received codeword
//   out_valid/out_ready: output handshake for the result registers
//   data_out           : corrected data (raw data when uncorrectable)
//   error_detected     : any nonzero syndrome
//   error_corrected    : single error repaired, or parity-only error
//   err_pos            : corrected codeword bit index 0..14, 15 = none
//   corrected_count    : saturating count of delivered corrected results
//   uncorr_count       : saturating count of delivered uncorrectable results
//   clear_counts       : synchronous clear of both counters (wins over count)
module three_d_memory_ecc_corrector #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned CODEWORD_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CODEWORD_WIDTH-1:0] codeword_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     data_out,
  output logic                      error_detected,
  output logic                      error_corrected,
  output logic [3:0]                err_pos,
  output logic [COUNT_WIDTH-1:0]    corrected_count,
  output logic [COUNT_WIDTH-1:0]    uncorr_count,
  input  logic                      clear_counts
);

  localparam logic [3:0] POS_NONE = 4'd15;

  // Stage 1 registers: raw data plus syndromes
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_data;
  logic [3:0]            r_s1_le;
  logic [1:0]            r_s1_be;
  logic                  r_s1_oe;

  logic                  w_s2_ready;
  logic                  w_s1_ready;
  logic                  w_out_hs;
  logic [DATA_WIDTH-1:0] w_in_data;
  logic [3:0]            w_in_le;
  logic [1:0]            w_in_be;
  logic                  w_in_oe;
  logic                  w_unused_bit15;

  logic [6:0]            w_syn;
  logic [DATA_WIDTH-1:0] w_fix_data;
  logic                  w_fix_det;
  logic                  w_fix_cor;
  logic [3:0]            w_fix_pos;

  // Ready chain: each stage can load when empty or when its consumer drains
  assign w_s2_ready = !out_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign in_ready   = w_s1_ready && !rst;
  assign w_out_hs   = out_valid && out_ready;

  // Syndromes: stored parity XOR recomputed parity
  assign w_in_data = codeword_in[DATA_WIDTH-1:0];
  assign w_in_le   = codeword_in[11:8] ^ {w_in_data[7] ^ w_in_data[6],
                                          w_in_data[5] ^ w_in_data[4],
                                          w_in_data[3] ^ w_in_data[2],
                                          w_in_data[1] ^ w_in_data[0]};
  assign w_in_be   = codeword_in[13:12] ^
                     {w_in_data[1] ^ w_in_data[3] ^ w_in_data[5] ^ w_in_data[7],
                      w_in_data[0] ^ w_in_data[2] ^ w_in_data[4] ^ w_in_data[6]};
  assign w_in_oe   = codeword_in[14] ^ (^w_in_data);
  assign w_unused_bit15 = codeword_in[15];

  // Stage 1 capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_le    <= '0;
      r_s1_be    <= '0;
      r_s1_oe    <= 1'b0;
    end else if (w_s1_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_in_data;
        r_s1_le   <= w_in_le;
        r_s1_be   <= w_in_be;
        r_s1_oe   <= w_in_oe;
      end
    end
  end

  // Syndrome bit i maps to codeword parity bit 8+i
  assign w_syn = {r_s1_oe, r_s1_be, r_s1_le};

  // Classification and correction
  always_comb begin
    w_fix_data = r_s1_data;
    w_fix_det  = |w_syn;
    w_fix_cor  = 1'b0;
    w_fix_pos  = POS_NONE;
    if (w_syn == 7'd0) begin
      w_fix_det = 1'b0;
    end else if ($onehot(r_s1_le) && $onehot(r_s1_be) && r_s1_oe) begin
      // Layer and bit-lane syndromes intersect at the failing data bit
      for (int l = 0; l < 4; l++) begin
        for (int b = 0; b < 2; b++) begin
          if (r_s1_le[l] && r_s1_be[b]) begin
            w_fix_pos = 4'(2 * l + b);
          end
        end
      end
      w_fix_data = r_s1_data ^ (DATA_WIDTH'(1) << w_fix_pos[2:0]);
      w_fix_cor  = 1'b1;
    end else if ($onehot(w_syn)) begin
      // Lone syndrome bit: the parity bit itself flipped, data is intact
      for (int i = 0; i < 7; i++) begin
        if (w_syn[i]) begin
          w_fix_pos = 4'(8 + i);
        end
      end
      w_fix_cor = 1'b1;
    end
  end

  // Stage 2 result registers, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid       <= 1'b0;
      data_out        <= '0;
      error_detected  <= 1'b0;
      error_corrected <= 1'b0;
      err_pos         <= POS_NONE;
    end else if (w_s2_ready) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        data_out        <= w_fix_data;
        error_detected  <= w_fix_det;
        error_corrected <= w_fix_cor;
        err_pos         <= w_fix_pos;
      end
    end
  end

  // Event counters advance on delivered results only, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst || clear_counts) begin
      corrected_count <= '0;
      uncorr_count    <= '0;
    end else if (w_out_hs) begin
      if (error_corrected && (corrected_count != '1)) begin
        corrected_count <= corrected_count + COUNT_WIDTH'(1);
      end
      if (error_detected && !error_corrected && (uncorr_count != '1)) begin
        uncorr_count <= uncorr_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule
